// File: rtl/nwc_pkg.sv
// rtl/nwc_pkg.sv - shared constants and loader state type for the NWC input path
// Contents: frame geometry (LOG_N, N, NWC_WORDS), coefficient/word widths,
// and the loader FSM state enum.
package nwc_pkg;

  localparam int LOG_N     = 12;
  localparam int N         = 1 << LOG_N;
  localparam int NWC_WORDS = N / 2;
  localparam int COEF_W    = 30;
  localparam int WORD_W    = 2 * COEF_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FIRE  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } loader_state_t;

endpackage

// File: rtl/nwc_input_loader_if.sv
// rtl/nwc_input_loader_if.sv - coefficient-pair valid/ready stream into the loader
// Signals: in_valid/in_ready handshake, in_coef_a/in_coef_b operand
// coefficients, in_last end-of-frame marker.
// Modports: master = coefficient source, slave = loader.
interface nwc_input_loader_if #(
  parameter int COEF_W = nwc_pkg::COEF_W
);

  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef_a;
  logic [COEF_W-1:0] in_coef_b;
  logic              in_last;

  modport master (
    output in_valid,
    output in_coef_a,
    output in_coef_b,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_coef_a,
    input  in_coef_b,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/nwc_coef_packer.sv
// rtl/nwc_coef_packer.sv - packs coefficient pairs into 60-bit processor words
// Ports: clk, rst_n (async, active-low); beat_i accepted-beat strobe;
// coef_a_i/coef_b_i beat data; write_enable_o one-cycle registered strobe;
// data0_o/data1_o packed words {odd, even} for operands A and B.
module nwc_coef_packer #(
  parameter int COEF_W = nwc_pkg::COEF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                beat_i,
  input  logic [COEF_W-1:0]   coef_a_i,
  input  logic [COEF_W-1:0]   coef_b_i,
  output logic                write_enable_o,
  output logic [2*COEF_W-1:0] data0_o,
  output logic [2*COEF_W-1:0] data1_o
);

  // Low while waiting for the even coefficient of a pair, high for the odd one.
  logic                phase_q;
  logic [COEF_W-1:0]   hold_a_q;
  logic [COEF_W-1:0]   hold_b_q;
  logic                we_q;
  logic [2*COEF_W-1:0] data0_q;
  logic [2*COEF_W-1:0] data1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      we_q     <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (beat_i) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hold_a_q <= coef_a_i;
          hold_b_q <= coef_b_i;
        end else begin
          // Even coefficient occupies the low half of the word.
          data0_q <= {coef_a_i, hold_a_q};
          data1_q <= {coef_b_i, hold_b_q};
          we_q    <= 1'b1;
        end
      end
    end
  end

  assign write_enable_o = we_q;
  assign data0_o        = data0_q;
  assign data1_o        = data1_q;

endmodule

// File: rtl/nwc_input_loader.sv
// rtl/nwc_input_loader.sv - frames coefficient pairs into 2048 processor writes plus start
// Ports: clk, rst_n (async, active-low); s_in coefficient stream (slave);
// nwc_write_enable/nwc_data_in0/nwc_data_in1 processor write port;
// nwc_start one-cycle start pulse; nwc_ready, nwc_output_active processor
// status; busy (not IDLE); err sticky framing error.
module nwc_input_loader #(
  parameter int COEF_W = nwc_pkg::COEF_W,
  parameter int LOG_N  = nwc_pkg::LOG_N
) (
  input  logic                clk,
  input  logic                rst_n,
  nwc_input_loader_if.slave   s_in,
  output logic                nwc_write_enable,
  output logic [2*COEF_W-1:0] nwc_data_in0,
  output logic [2*COEF_W-1:0] nwc_data_in1,
  output logic                nwc_start,
  input  logic                nwc_ready,
  input  logic                nwc_output_active,
  output logic                busy,
  output logic                err
);

  import nwc_pkg::*;

  localparam logic [LOG_N-1:0] IDX_LAST = '1;

  loader_state_t    state_q, state_d;
  logic [LOG_N-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             start_q;
  logic             beat;
  logic             at_last;

  // Ready is decoded from registered state only, never from in_valid.
  assign s_in.in_ready = (state_q == S_LOAD);
  assign beat          = s_in.in_valid & s_in.in_ready;
  assign at_last       = (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;

    // Framing is purely count-based; in_last only feeds the error flag.
    if (beat) begin
      idx_d = idx_q + 1'b1;
      if (s_in.in_last != at_last) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE:  if (nwc_ready)          state_d = S_LOAD;
      S_LOAD:  if (beat && at_last)    state_d = S_FIRE;
      S_FIRE:                          state_d = S_RUN;
      S_RUN:   if (nwc_output_active)  state_d = S_DRAIN;
      S_DRAIN: if (!nwc_output_active) state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      // Registered off FIRE so start follows the final write by one cycle.
      start_q <= (state_q == S_FIRE);
    end
  end

  nwc_coef_packer #(
    .COEF_W(COEF_W)
  ) u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .beat_i        (beat),
    .coef_a_i      (s_in.in_coef_a),
    .coef_b_i      (s_in.in_coef_b),
    .write_enable_o(nwc_write_enable),
    .data0_o       (nwc_data_in0),
    .data1_o       (nwc_data_in1)
  );

  assign nwc_start = start_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_nwc_input_loader.sv
// tb/tb_nwc_input_loader.sv - randomized self-checking bench for nwc_input_loader
module tb_nwc_input_loader;

  localparam int CW = 30;
  localparam int NB = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          nwc_ready;
  logic          nwc_output_active;
  logic          nwc_write_enable;
  logic [2*CW-1:0] nwc_data_in0;
  logic [2*CW-1:0] nwc_data_in1;
  logic          nwc_start;
  logic          busy;
  logic          err;

  nwc_input_loader_if #(.COEF_W(CW)) s_if ();

  nwc_input_loader #(.COEF_W(CW), .LOG_N(12)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_in             (s_if),
    .nwc_write_enable (nwc_write_enable),
    .nwc_data_in0     (nwc_data_in0),
    .nwc_data_in1     (nwc_data_in1),
    .nwc_start        (nwc_start),
    .nwc_ready        (nwc_ready),
    .nwc_output_active(nwc_output_active),
    .busy             (busy),
    .err              (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 waiting for processor, 1 loading,
  // 2 frame loaded awaiting result, 3 result streaming.
  int          m_mode = 0;
  int          m_beats = 0;
  bit          m_err = 0, m_we = 0, m_start = 0, m_pend = 0;
  logic [CW-1:0]   m_ha = '0, m_hb = '0;
  logic [2*CW-1:0] m_d0 = '0, m_d1 = '0;
  int          cyc = 0, wcnt = 0, cap_words = 0, start_cyc = 0, last_acc_cyc = 0;
  logic [2*CW-1:0] cap_w0_d0, cap_w0_d1, cap_wl_d0, cap_wl_d1;

  always @(negedge clk) begin
    bit acc, fin, n_we;
    cyc++;
    if (!rst_n) begin
      check("reset_ctrl", {nwc_write_enable, nwc_start, busy, err, s_if.in_ready}, 64'd0);
      check("reset_data", {4'd0, nwc_data_in0 | nwc_data_in1}, 64'd0);
      m_mode = 0; m_beats = 0; m_err = 0; m_we = 0; m_start = 0; m_pend = 0;
      m_ha = '0; m_hb = '0; wcnt = 0;
    end else begin
      check("in_ready", s_if.in_ready, m_mode == 1);
      check("busy", busy, m_mode != 0);
      check("err", err, m_err);
      check("write_enable", nwc_write_enable, m_we);
      check("start", nwc_start, m_start);
      if (m_we) begin
        check("data_in0", nwc_data_in0, m_d0);
        check("data_in1", nwc_data_in1, m_d1);
      end
      if (nwc_write_enable) begin
        if (wcnt == 0) begin cap_w0_d0 = nwc_data_in0; cap_w0_d1 = nwc_data_in1; end
        if (wcnt == NB/2-1) begin cap_wl_d0 = nwc_data_in0; cap_wl_d1 = nwc_data_in1; end
        wcnt++;
      end
      if (nwc_start) begin
        cap_words = wcnt; wcnt = 0; start_cyc = cyc;
      end

      // Advance model to the next cycle.
      acc  = s_if.in_valid && (m_mode == 1);
      fin  = acc && (m_beats == NB-1);
      n_we = 0;
      if (acc) begin
        if (m_beats % 2 == 0) begin
          m_ha = s_if.in_coef_a; m_hb = s_if.in_coef_b;
        end else begin
          n_we = 1;
          m_d0 = {s_if.in_coef_a, m_ha};
          m_d1 = {s_if.in_coef_b, m_hb};
        end
        if (s_if.in_last != fin) m_err = 1;
        if (fin) last_acc_cyc = cyc;
        m_beats = (m_beats + 1) % NB;
      end
      m_we    = n_we;
      m_start = m_pend;
      m_pend  = fin;
      case (m_mode)
        0: if (nwc_ready) m_mode = 1;
        1: if (fin) m_mode = 2;
        2: if (nwc_output_active) m_mode = 3;
        default: if (!nwc_output_active) m_mode = 0;
      endcase
    end
  end

  // Presents beats 0..stop-1 of a frame; caller is just after a posedge.
  task automatic drive_frame(input int stop, input bit gaps, input bit rnd, input int bad);
    int i = 0;
    int stall = 0;
    logic [CW-1:0] a, b;
    a = rnd ? CW'($urandom()) : CW'(0);
    b = rnd ? CW'($urandom()) : CW'(NB-1);
    while (i < stop) begin
      s_if.in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.in_coef_a = a;
      s_if.in_coef_b = b;
      s_if.in_last   = (i == NB-1) || (i == bad);
      @(negedge clk);
      if (s_if.in_valid && s_if.in_ready) begin
        i++;
        stall = 0;
        a = rnd ? CW'($urandom()) : CW'(i);
        b = rnd ? CW'($urandom()) : CW'(NB-1-i);
      end else begin
        stall++;
        if (stall > 200) begin
          check("drive_timeout", 64'(stall), 64'd0);
          break;
        end
      end
      @(posedge clk); #1;
    end
    s_if.in_valid = 1'b0;
    s_if.in_last  = 1'b0;
  endtask

  // Waits for start, then plays a 2048-cycle result stream.
  task automatic run_processor();
    bit found = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (nwc_start) begin found = 1; break; end
    end
    check("start_seen", found, 1);
    @(posedge clk); #1;
    nwc_output_active = 1'b1;
    repeat (2048) begin
      @(negedge clk);
      check("busy_while_active", busy, 1);
    end
    @(posedge clk); #1;
    nwc_output_active = 1'b0;
    @(negedge clk);
    check("busy_at_fall", busy, 1);
    @(negedge clk);
    check("idle_after_fall", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    nwc_ready = 1'b0;
    nwc_output_active = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_coef_a = '0;
    s_if.in_coef_b = '0;
    s_if.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", s_if.in_ready, 0);
    check("rst_we", nwc_write_enable, 0);
    rst_n = 1'b1;

    // Processor not ready for 10 cycles: no acceptance, no strobes.
    repeat (10) @(posedge clk);
    #1;
    check("not_ready_in_ready", s_if.in_ready, 0);
    check("not_ready_busy", busy, 0);
    nwc_ready = 1'b1;
    @(negedge clk);
    check("ready_sampled_in_ready", s_if.in_ready, 0);
    @(negedge clk);
    check("load_in_ready", s_if.in_ready, 1);
    @(posedge clk); #1;

    // Frame 1: back-to-back ramp.
    drive_frame(NB, 0, 0, -1);
    run_processor();
    check("f1_words", 64'(cap_words), 64'd2048);
    check("f1_w0_d0", cap_w0_d0, {30'd1, 30'd0});
    check("f1_w0_d1", cap_w0_d1, {30'd4094, 30'd4095});
    check("f1_wl_d0", cap_wl_d0, {30'd4095, 30'd4094});
    check("f1_wl_d1", cap_wl_d1, {30'd0, 30'd1});
    check("f1_start_latency", 64'(start_cyc - last_acc_cyc), 64'd2);
    check("f1_err", err, 0);

    // Frame 2: same ramp with random gaps and a stray in_last at idx 100.
    drive_frame(NB, 1, 0, 100);
    run_processor();
    check("f2_words", 64'(cap_words), 64'd2048);
    check("f2_w0_d0", cap_w0_d0, {30'd1, 30'd0});
    check("f2_wl_d1", cap_wl_d1, {30'd0, 30'd1});
    check("f2_err_sticky", err, 1);

    // Frame 3: random data, reset at beat 1000.
    drive_frame(1000, 1, 1, -1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", nwc_write_enable, 0);
    check("async_rst_d0", nwc_data_in0, 0);
    check("async_rst_d1", nwc_data_in1, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err, 0);
    check("async_rst_in_ready", s_if.in_ready, 0);
    check("async_rst_start", nwc_start, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Frame 4: full random frame must align from idx 0 after reset.
    drive_frame(NB, 0, 1, -1);
    run_processor();
    check("f4_words", 64'(cap_words), 64'd2048);
    check("f4_err", err, 0);
    check("f4_start_latency", 64'(start_cyc - last_acc_cyc), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
